// File: rtl/blink_sequencer_if.sv
// Configuration handshake bundle for blink_sequencer: one valid/ready offer
// carrying the four pattern fields.
interface blink_sequencer_if;
  logic       cfg_valid;
  logic [3:0] cfg_on;
  logic [3:0] cfg_off;
  logic [3:0] cfg_count;
  logic [3:0] cfg_pause;
  logic       cfg_ready;

  modport master (
    output cfg_valid, cfg_on, cfg_off, cfg_count, cfg_pause,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_on, cfg_off, cfg_count, cfg_pause,
    output cfg_ready
  );
endinterface

// File: rtl/blink_sequencer.sv
// LED burst generator: N blinks then a pause, timed in prescaler ticks. New
// configuration waits in a shadow register and is adopted only at burst edges.
module blink_sequencer #(
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned PRESCALE = 3000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  blink_sequencer_if.slave   cfg_if,
  output logic               led_o,
  output logic               busy_o,
  output logic               burst_done_o,
  output logic               tick_o,
  output logic [CNT_W-1:0]   presc_o
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_PAUSE} state_t;

  typedef struct packed {
    logic [3:0] on;
    logic [3:0] off;
    logic [3:0] count;
    logic [3:0] pause;
  } cfg_t;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(PRESCALE - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   presc_q, presc_d;
  logic [3:0]         phase_q, phase_d;
  logic [3:0]         blink_q, blink_d;
  cfg_t               act_q, act_d;
  cfg_t               shadow_q, shadow_d;
  logic               pending_q, pending_d;
  logic               led_q, led_d;

  cfg_t               cfg_in;
  logic               tick;
  logic               xfer;
  logic               load;
  logic               reload;
  logic               burst_done;
  logic               phase_end;
  logic [3:0]         phase_len;

  assign cfg_in = '{on: cfg_if.cfg_on, off: cfg_if.cfg_off,
                    count: cfg_if.cfg_count, pause: cfg_if.cfg_pause};

  // Presc is held at 0 in IDLE and PRESCALE >= 2, so tick can never fire there.
  assign tick             = (presc_q == PRESC_LAST);
  assign cfg_if.cfg_ready = !rst && ((state_q == S_IDLE) || !pending_q);
  assign xfer             = cfg_if.cfg_valid && cfg_if.cfg_ready;

  always_comb begin
    phase_len = 4'd1;
    case (state_q)
      S_ON:    phase_len = (act_q.on  == 4'd0) ? 4'd1 : act_q.on;
      S_OFF:   phase_len = (act_q.off == 4'd0) ? 4'd1 : act_q.off;
      S_PAUSE: phase_len = act_q.pause;
      default: phase_len = 4'd1;
    endcase
  end

  assign phase_end = tick && (phase_q == phase_len - 4'd1);

  // NOTE: every signal written below gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    phase_d    = phase_q;
    blink_d    = blink_q;
    act_d      = act_q;
    shadow_d   = xfer ? cfg_in : shadow_q;
    load       = 1'b0;
    reload     = 1'b0;
    burst_done = 1'b0;

    if (state_q == S_IDLE) begin
      presc_d = '0;
      if (enable_i && shadow_q.count != 4'd0) begin
        load    = 1'b1;
        state_d = S_ON;
        phase_d = '0;
        blink_d = '0;
      end
    end else if (!enable_i) begin
      state_d = S_IDLE;
      presc_d = '0;
      phase_d = '0;
      blink_d = '0;
    end else begin
      if (tick) phase_d = phase_q + 4'd1;
      if (phase_end) begin
        phase_d = '0;
        case (state_q)
          S_ON: state_d = S_OFF;
          S_OFF: begin
            if ({1'b0, blink_q} + 5'd1 < {1'b0, act_q.count}) begin
              blink_d = blink_q + 4'd1;
              state_d = S_ON;
            end else begin
              burst_done = 1'b1;
              blink_d    = '0;
              if (act_q.pause != 4'd0) state_d = S_PAUSE;
              else                     reload  = 1'b1;
            end
          end
          default: reload = 1'b1;
        endcase
      end
      // Burst boundary: adopt the old shadow even if a new offer lands now.
      if (reload) begin
        load    = 1'b1;
        state_d = (shadow_q.count != 4'd0) ? S_ON : S_IDLE;
      end
    end

    if (load) act_d = shadow_q;

    if (xfer && (state_q != S_IDLE || load)) pending_d = 1'b1;
    else if (load)                           pending_d = 1'b0;
    else                                     pending_d = pending_q;

    led_d = (state_d == S_ON);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      phase_q   <= '0;
      blink_q   <= '0;
      act_q     <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      blink_q   <= blink_d;
      act_q     <= act_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      led_q     <= led_d;
    end
  end

  assign led_o        = led_q;
  assign busy_o       = (state_q != S_IDLE);
  assign burst_done_o = burst_done;
  assign tick_o       = tick;
  assign presc_o      = presc_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer: a pattern-arithmetic model predicts
// every output each cycle from the active config and the offset into the burst.
module tb_blink_sequencer;
  localparam int CNT_W = 8;
  localparam int P     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             led, busy, burst_done, tick;
  logic [CNT_W-1:0] presc;

  blink_sequencer_if cif ();

  blink_sequencer #(.CNT_W(CNT_W), .PRESCALE(P)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .cfg_if       (cif),
    .led_o        (led),
    .busy_o       (busy),
    .burst_done_o (burst_done),
    .tick_o       (tick),
    .presc_o      (presc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: running flag, cycle offset into the current burst, configs, pending.
  bit m_run;
  int m_t;
  int m_act[4];   // 0 on, 1 off, 2 count, 3 pause
  int m_sh[4];
  bit m_pend;

  task automatic model_reset();
    m_run = 0; m_t = 0; m_pend = 0;
    for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_sh[i] = 0; end
  endtask

  function automatic int on_len();  return (m_act[0] == 0) ? 1 : m_act[0]; endfunction
  function automatic int off_len(); return (m_act[1] == 0) ? 1 : m_act[1]; endfunction
  function automatic int active_len(); return m_act[2] * (on_len() + off_len()) * P; endfunction
  function automatic int burst_len();  return active_len() + m_act[3] * P; endfunction

  function automatic logic [12:0] model_out();
    logic [12:0] v;
    int blen, ph;
    v = '0;
    if (!m_run) begin
      v[8] = 1'b1;
      return v;
    end
    blen   = (on_len() + off_len()) * P;
    ph     = m_t % P;
    v[12]  = (m_t < active_len()) && ((m_t % blen) < on_len() * P);
    v[11]  = 1'b1;
    v[10]  = (m_t == active_len() - 1);
    v[9]   = (ph == P - 1);
    v[8]   = !m_pend;
    v[7:0] = 8'(ph);
    return v;
  endfunction

  function automatic logic [12:0] obs_out();
    return {led, busy, burst_done, tick, cif.cfg_ready, presc};
  endfunction

  task automatic model_edge(input bit en, input bit valid, input int on, off, cnt, pau);
    bit rdy, xfer;
    rdy  = !m_run || !m_pend;
    xfer = valid && rdy;
    if (!m_run) begin
      if (en && m_sh[2] != 0) begin
        m_act = m_sh; m_run = 1; m_t = 0; m_pend = xfer;
      end
    end else if (!en) begin
      m_run = 0; m_t = 0;
      if (xfer) m_pend = 1;
    end else if (m_t == burst_len() - 1) begin
      m_act = m_sh; m_pend = xfer; m_t = 0;
      if (m_sh[2] == 0) m_run = 0;
    end else begin
      m_t++;
      if (xfer) m_pend = 1;
    end
    if (xfer) begin
      m_sh[0] = on; m_sh[1] = off; m_sh[2] = cnt; m_sh[3] = pau;
    end
  endtask

  // Drive inputs at the falling edge, advance one clock, return at the next falling edge.
  task automatic step(input bit en, input bit valid, input int on, off, cnt, pau);
    enable        = en;
    cif.cfg_valid = valid;
    cif.cfg_on    = 4'(on);
    cif.cfg_off   = 4'(off);
    cif.cfg_count = 4'(cnt);
    cif.cfg_pause = 4'(pau);
    @(posedge clk);
    model_edge(en, valid, on, off, cnt, pau);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; cif.cfg_valid = 1'b0;
    cif.cfg_on = '0; cif.cfg_off = '0; cif.cfg_count = '0; cif.cfg_pause = '0;
    model_reset();
    #12;
    checks++;
    if (obs_out() !== 13'd0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", obs_out(), 13'd0);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (obs_out() !== model_out()) begin
      failures++; $display("FAIL reset_release got=%b exp=%b", obs_out(), model_out());
    end
    @(negedge clk);
  endtask

  task automatic test_basic_pattern();
    int led_hi = 0, bd_cnt = 0, tk_cnt = 0;
    step(0, 1, 2, 1, 3, 2);
    for (int i = 0; i < 46; i++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (obs_out() !== model_out()) begin
        failures++; $display("FAIL basic cyc=%0d got=%b exp=%b", i, obs_out(), model_out());
      end
      if (i < 44) begin led_hi += led; bd_cnt += burst_done; tk_cnt += tick; end
      if (i == 43) begin
        checks++;
        if (led !== 1'b0) begin failures++; $display("FAIL basic_pause_led got=%b exp=0", led); end
      end
      if (i == 44) begin
        checks++;
        if (led !== 1'b1) begin failures++; $display("FAIL basic_period_led got=%b exp=1", led); end
      end
    end
    checks++;
    if (led_hi != 24) begin failures++; $display("FAIL basic_led_high got=%0d exp=24", led_hi); end
    checks++;
    if (bd_cnt != 1) begin failures++; $display("FAIL basic_burst_done got=%0d exp=1", bd_cnt); end
    checks++;
    if (tk_cnt != 11) begin failures++; $display("FAIL basic_ticks got=%0d exp=11", tk_cnt); end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reconfig_midburst();
    int bd_cnt = 0, led_hi = 0;
    step(0, 1, 2, 1, 3, 2);
    for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 0);
    checks++;
    if (cif.cfg_ready !== 1'b0) begin
      failures++; $display("FAIL reconfig_ready_low got=%b exp=0", cif.cfg_ready);
    end
    for (int i = 0; i < 150; i++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (obs_out() !== model_out()) begin
        failures++; $display("FAIL reconfig cyc=%0d got=%b exp=%b", i, obs_out(), model_out());
      end
      if (i >= 70) begin bd_cnt += burst_done; led_hi += led; end
    end
    checks++;
    if (bd_cnt != 10) begin failures++; $display("FAIL reconfig_bursts got=%0d exp=10", bd_cnt); end
    checks++;
    if (led_hi != 40) begin failures++; $display("FAIL reconfig_led_high got=%0d exp=40", led_hi); end
    checks++;
    if (cif.cfg_ready !== 1'b1) begin
      failures++; $display("FAIL reconfig_ready_back got=%b exp=1", cif.cfg_ready);
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_count_zero();
    step(0, 1, 2, 1, 0, 2);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (obs_out() !== model_out() || busy !== 1'b0 || led !== 1'b0) begin
        failures++; $display("FAIL count_zero cyc=%0d got=%b exp=%b", i, obs_out(), model_out());
      end
    end
    step(1, 1, 2, 1, 2, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (led !== 1'b1 || busy !== 1'b1 || obs_out() !== model_out()) begin
      failures++; $display("FAIL count_zero_start got=%b exp=%b", obs_out(), model_out());
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_zero_lengths();
    step(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (obs_out() !== model_out() || led !== ((i % 8) < 4)) begin
        failures++; $display("FAIL zero_len cyc=%0d got=%b exp=%b", i, obs_out(), model_out());
      end
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_enable_drop();
    step(0, 1, 2, 1, 3, 2);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (led !== 1'b0 || busy !== 1'b0 || presc !== '0) begin
      failures++; $display("FAIL enable_drop got=%b exp=%b", obs_out(), model_out());
    end
    for (int j = 0; j < 9; j++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (obs_out() !== model_out() || led !== (j < 8)) begin
        failures++; $display("FAIL reenable cyc=%0d got=%b exp=%b", j, obs_out(), model_out());
      end
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    step(0, 1, 2, 1, 3, 2);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_out() !== 13'd0) begin
      failures++; $display("FAIL async_reset got=%b exp=%b", obs_out(), 13'd0);
    end
    model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (obs_out() !== model_out() || busy !== 1'b0) begin
        failures++; $display("FAIL post_reset_idle cyc=%0d got=%b exp=%b", i, obs_out(), model_out());
      end
    end
    step(1, 1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (busy !== 1'b1 || obs_out() !== model_out()) begin
      failures++; $display("FAIL post_reset_start got=%b exp=%b", obs_out(), model_out());
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit en, vl;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 99) != 0);
      vl = ($urandom_range(0, 19) == 0);
      step(en, vl, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3));
      checks++;
      if (obs_out() !== model_out()) begin
        failures++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_out(), model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pattern();
    test_reconfig_midburst();
    test_count_zero();
    test_zero_lengths();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
